// File: rtl/sysarr_pkg.sv
// Shared defaults and types for the systolic-array input path.
// Used by sysarr_row_fifo and sysarr_input_fifo_bank.
package sysarr_pkg;

  localparam int ARRAY_DIM_DEF = 4;
  localparam int DATA_W_DEF    = 16;

  typedef logic [15:0] fp16_t;

  // Index width that stays at least one bit wide for degenerate sizes.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef logic [idx_w(ARRAY_DIM_DEF)-1:0] row_idx_t;
  typedef logic [idx_w(ARRAY_DIM_DEF)-1:0] elem_idx_t;

endpackage

// File: rtl/sysarr_row_fifo.sv
// One row of the input FIFO bank: NSLOT whole-vector slots, presented
// one element at a time to the leftmost MAC of the row.
// Optional sticky error flags when SYSARR_INFIFO_ERR_EN is defined.
module sysarr_row_fifo
  import sysarr_pkg::*;
#(
  parameter int ARRAY_DIM = ARRAY_DIM_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int NSLOT     = 2
) (
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic                        load_en,
  input  logic [ARRAY_DIM*DATA_W-1:0] load_vec,
  input  logic                        shift,
  input  logic                        enable,
  output logic [DATA_W-1:0]           head_data,
  output logic                        valid,
  output logic                        has_space
`ifdef SYSARR_INFIFO_ERR_EN
  ,
  output logic                        overflow_err,
  output logic                        underflow_err
`endif
);

  localparam int PTR_W  = idx_w(NSLOT);
  localparam int CNT_W  = $clog2(NSLOT + 1);
  localparam int EIDX_W = idx_w(ARRAY_DIM);

  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(NSLOT - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(NSLOT);
  localparam logic [EIDX_W-1:0] EIDX_LAST = EIDX_W'(ARRAY_DIM - 1);

  logic [ARRAY_DIM*DATA_W-1:0] mem_q [NSLOT];

  logic [PTR_W-1:0]  head_ptr_q, head_ptr_d;
  logic [PTR_W-1:0]  tail_ptr_q, tail_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [EIDX_W-1:0] elem_idx_q, elem_idx_d;

  logic shift_ok;
  logic head_done;
  logic load_ok;
  logic [ARRAY_DIM*DATA_W-1:0] head_vec;

  // Slot pointers wrap by explicit compare so NSLOT need not be a power of 2.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign shift_ok  = shift && (count_q != '0);
  assign head_done = shift_ok && (elem_idx_q == EIDX_LAST);
  // A full row can still accept when the same-edge shift frees the head slot.
  assign load_ok   = load_en && ((count_q != CNT_FULL) || head_done);

  assign valid     = (count_q != '0);
  assign has_space = (count_q != CNT_FULL);
  assign head_vec  = mem_q[head_ptr_q];
  assign head_data = (enable && valid) ? head_vec[elem_idx_q*DATA_W +: DATA_W] : '0;

  // Next-state for pointers, occupancy and element index.
  always_comb begin
    head_ptr_d = head_ptr_q;
    tail_ptr_d = tail_ptr_q;
    count_d    = count_q;
    elem_idx_d = elem_idx_q;

    if (shift_ok) begin
      if (head_done) begin
        elem_idx_d = '0;
        head_ptr_d = ptr_inc(head_ptr_q);
      end else begin
        elem_idx_d = elem_idx_q + EIDX_W'(1);
      end
    end

    if (load_ok) begin
      tail_ptr_d = ptr_inc(tail_ptr_q);
    end

    case ({load_ok, head_done})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register; reset empties the row immediately.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      head_ptr_q <= '0;
      tail_ptr_q <= '0;
      count_q    <= '0;
      elem_idx_q <= '0;
    end else begin
      head_ptr_q <= head_ptr_d;
      tail_ptr_q <= tail_ptr_d;
      count_q    <= count_d;
      elem_idx_q <= elem_idx_d;
    end
  end

  // Slot storage carries no reset; stale contents are hidden by count.
  always_ff @(posedge CLK) begin
    if (load_ok) begin
      mem_q[tail_ptr_q] <= load_vec;
    end
  end

`ifdef SYSARR_INFIFO_ERR_EN
  logic overflow_q;
  logic underflow_q;

  // Sticky flags: dropped load and shift-while-empty; cleared only by reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (load_en && !load_ok)       overflow_q  <= 1'b1;
      if (shift && (count_q == '0))  underflow_q <= 1'b1;
    end
  end

  assign overflow_err  = overflow_q;
  assign underflow_err = underflow_q;
`endif

endmodule

// File: rtl/sysarr_input_fifo_bank.sv
// Bank of ARRAY_DIM per-row input FIFOs feeding the systolic-array rows.
// Define SYSARR_INFIFO_ERR_EN to add sticky overflow_err/underflow_err outputs.
module sysarr_input_fifo_bank
  import sysarr_pkg::*;
#(
  parameter int ARRAY_DIM = ARRAY_DIM_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int NSLOT     = 2
) (
  input  logic                          CLK,
  input  logic                          nRST,
  input  logic                          input_load,
  input  logic [idx_w(ARRAY_DIM)-1:0]   input_row,
  input  logic [ARRAY_DIM*DATA_W-1:0]   load_data,
  input  logic [ARRAY_DIM-1:0]          fifo_shift,
  input  logic [ARRAY_DIM-1:0]          fifo_enable,
  output logic [ARRAY_DIM*DATA_W-1:0]   row_data,
  output logic [ARRAY_DIM-1:0]          row_valid,
  output logic                          fifo_has_space
`ifdef SYSARR_INFIFO_ERR_EN
  ,
  output logic [ARRAY_DIM-1:0]          overflow_err,
  output logic [ARRAY_DIM-1:0]          underflow_err
`endif
);

  localparam int ROW_W = idx_w(ARRAY_DIM);

  logic [ARRAY_DIM-1:0] load_en;
  logic [ARRAY_DIM-1:0] has_space;

  genvar gi;
  generate
    for (gi = 0; gi < ARRAY_DIM; gi++) begin : g_row
      // Row decode; an out-of-range row index matches no instance.
      assign load_en[gi] = input_load && (input_row == ROW_W'(gi));

      sysarr_row_fifo #(
        .ARRAY_DIM (ARRAY_DIM),
        .DATA_W    (DATA_W),
        .NSLOT     (NSLOT)
      ) u_row (
        .CLK           (CLK),
        .nRST          (nRST),
        .load_en       (load_en[gi]),
        .load_vec      (load_data),
        .shift         (fifo_shift[gi]),
        .enable        (fifo_enable[gi]),
        .head_data     (row_data[gi*DATA_W +: DATA_W]),
        .valid         (row_valid[gi]),
        .has_space     (has_space[gi])
`ifdef SYSARR_INFIFO_ERR_EN
        ,
        .overflow_err  (overflow_err[gi]),
        .underflow_err (underflow_err[gi])
`endif
      );
    end
  endgenerate

  assign fifo_has_space = &has_space;

endmodule

// File: doc/sysarr_input_fifo_bank.md
Name: sysarr_input_fifo_bank

Overview:
- Bank of ARRAY_DIM per-row input FIFOs sitting between the memory-side load path and the systolic-array MAC rows.
- Consumes the control unit's input_load, input_row, fifo_shift and fifo_enable.
- Returns fifo_has_space to the control unit.
- Each row buffers whole input vectors and presents one element per shift to the leftmost MAC of its row.

Parameters:
- ARRAY_DIM, 4, array rows and elements per input vector
- DATA_W, 16, element width (FP16)
- NSLOT, 2, vector slots per row FIFO (>=1; need not be a power of 2)

Ports:
- CLK  input  1  system clock
- nRST  input  1  asynchronous active-low reset
- input_load  input  1  write load_data into the row selected by input_row
- input_row  input  $clog2(ARRAY_DIM)  target row for load
- load_data  input  ARRAY_DIM*DATA_W  input vector; element k at bits [k*DATA_W +: DATA_W]
- fifo_shift  input  ARRAY_DIM  per-row pop of one element
- fifo_enable  input  ARRAY_DIM  per-row output enable (0 forces zero to the MAC)
- row_data  output  ARRAY_DIM*DATA_W  current head element per row, row r at [r*DATA_W +: DATA_W]
- row_valid  output  ARRAY_DIM  row r holds at least one unconsumed element
- fifo_has_space  output  1  every row has at least one free slot

Behaviour:
- Single clock, CLK rising edge. Reset is asynchronous active-low on nRST; it clears all state immediately, including mid-operation.
- Reset values:
  - all slots empty; head/tail slot pointers 0; element index 0
  - row_data 0; row_valid 0; fifo_has_space 1
- Per-row state:
  - slot storage NSLOT x ARRAY_DIM x DATA_W
  - head_ptr, tail_ptr in 0..NSLOT-1
  - count in 0..NSLOT, width $clog2(NSLOT+1)
  - elem_idx in 0..ARRAY_DIM-1
- Pointer wrap: explicit compare to NSLOT-1, then return to 0 (no power-of-2 reliance).
- Outputs (combinational from registered state, zero-latency read):
  - row_valid[r] = (count[r] != 0)
  - row_data[r] = fifo_enable[r] && row_valid[r] ? slot[head_ptr][elem_idx] : 0
  - fifo_has_space = AND over r of (count[r] < NSLOT)
- Load (one row per cycle):
  - Accepted when count[row] < NSLOT, or when the same-cycle shift on that row completes its head slot.
  - On accept: write the full vector at tail_ptr, advance tail_ptr, count+1.
  - When count == NSLOT and no completing shift: the load is dropped and the FIFO is unchanged.
- Shift:
  - When fifo_shift[r] && count[r] != 0: elem_idx+1.
  - If elem_idx was ARRAY_DIM-1: elem_idx to 0, head_ptr advances, count-1.
  - Shift with count == 0: ignored.
- fifo_enable does not gate shifting; it only masks data.
- Simultaneous load and completing shift on the same full row: both occur, count unchanged, and the new vector occupies the freed slot.
- Simultaneous load and non-completing shift: independent.
- New data is visible at row_data one cycle after the load edge, when the row was empty.
- Out-of-range input_row (only possible when ARRAY_DIM is not a power of 2): load ignored.

Optional Feature:
- Macro: SYSARR_INFIFO_ERR_EN
- Defined: adds outputs overflow_err (ARRAY_DIM) and underflow_err (ARRAY_DIM), both sticky per-row flags.
  - overflow_err is set on a dropped load.
  - underflow_err is set on a shift while empty.
  - Both clear only on nRST.
- Undefined: ports absent; drops and ignored shifts are silent.

Decomposition:
- Package sysarr_pkg holds:
  - ARRAY_DIM/DATA_W defaults
  - typedef fp16_t logic [15:0]
  - row_idx_t [$clog2(ARRAY_DIM)-1:0]
  - elem_idx_t
- Sub-module sysarr_row_fifo: one row's slots, pointers, count and element index.
  - ports: load_en, load_vec, shift, enable, head_data, valid, has_space (plus err flags under the macro)
- Top level:
  - decodes input_row into per-row load_en
  - generate-loops ARRAY_DIM instances
  - ANDs has_space into fifo_has_space

Test Plan:
- Reset: hold nRST=0 -> row_data=0, row_valid=0, fifo_has_space=1. Release and idle 5 cycles -> unchanged.
- Load and drain:
  - load row 1 with elements {4,3,2,1} (elem0=1), fifo_enable=4'b1111 -> next cycle row_valid=4'b0010, row_data[1]=1.
  - 4 shifts on row 1 -> row_data[1]=2,3,4, then row_valid[1]=0, row_data[1]=0.
- Full and completing shift:
  - load row 0 twice (A, B) -> fifo_has_space=0.
  - third load C with no shift -> dropped (overflow_err[0]=1 under macro). Drain yields A0..A3, B0..B3, no C.
  - repeat with C issued on the cycle of A's 4th shift -> C accepted; drain yields B then C.
- Enable mask: load row 2, fifo_enable[2]=0 -> row_data[2]=0 while row_valid[2]=1. Shift with the mask still advances; enable=1 then shows the next element.
- Underflow: shift row 3 while empty -> state unchanged (underflow_err[3]=1 under macro). A subsequent load and read return correct data.
- Reset mid-drain: assert nRST async between edges with row 0 at elem_idx 2 -> all outputs return to reset values immediately. After release, row 0 is empty.
